// File: rtl/multiplier_radix_taint_track.sv
// -----------------------------------------------------------------------------
// multiplier_radix_taint_track
//
// Constant-time sequential multiplier, radix 2^RADIX_BITS, with word-level taint
// tracking. Every operation takes exactly NCYC = WIDTH/RADIX_BITS RUN cycles,
// whatever the operand values. Taint follows the data path (operand word taints)
// and the control path (handshake taints). Control taint is sticky until reset,
// so any timing that depends on tainted control is flagged.
//
// Optional feature macro: MULT_SIGNED_EN
//   When defined, the ports signed_mode / signed_mode_t are added. They select a
//   two's-complement multiply and are latched at accept. When undefined, the
//   block multiplies unsigned operands only.
//
// Ports
//   clk             in   1        clock, rising edge
//   rst             in   1        asynchronous reset, active low
//   in_valid        in   1        operands valid
//   in_valid_t      in   1        taint of in_valid
//   in_ready        out  1        block can accept (IDLE only)
//   in_ready_t      out  1        taint of in_ready
//   multiplier      in   WIDTH    operand A
//   multiplier_t    in   1        word taint of A
//   multiplicand    in   WIDTH    operand B
//   multiplicand_t  in   1        word taint of B
//   out_valid       out  1        product valid
//   out_valid_t     out  1        taint of out_valid
//   out_ready       in   1        consumer accepts product
//   out_ready_t     in   1        taint of out_ready
//   product         out  2*WIDTH  A*B
//   product_t       out  1        word taint of product
//   signed_mode     in   1        (MULT_SIGNED_EN) two's-complement operands
//   signed_mode_t   in   1        (MULT_SIGNED_EN) taint of signed_mode
// -----------------------------------------------------------------------------
module multiplier_radix_taint_track #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_valid_t,
    output logic                 in_ready,
    output logic                 in_ready_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 multiplicand_t,
    output logic                 out_valid,
    output logic                 out_valid_t,
    input  logic                 out_ready,
    input  logic                 out_ready_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t
`ifdef MULT_SIGNED_EN
    ,
    input  logic                 signed_mode,
    input  logic                 signed_mode_t
`endif
);

    localparam int NCYC = WIDTH / RADIX_BITS;
    localparam int PW   = 2 * WIDTH;
    localparam int AW   = PW + RADIX_BITS;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (RADIX_BITS < 1 || RADIX_BITS > WIDTH) begin : g_bad_radix
            $error("multiplier_radix_taint_track: RADIX_BITS must be in 1..WIDTH");
        end
        if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_width
            $error("multiplier_radix_taint_track: WIDTH must be a multiple of RADIX_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       mr_q;
    logic [AW-1:0]          md_q;      // multiplicand pre-extended to accumulator width
    logic                   a_neg_q;   // signed mode and A negative
    logic [AW-1:0]          acc_q;
    logic                   data_t_q;
    logic                   ctrl_t_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    // Mode selection; the unsigned-only build ties these low.
    logic signed_sel;
    logic signed_t_sel;
`ifdef MULT_SIGNED_EN
    assign signed_sel   = signed_mode;
    assign signed_t_sel = signed_mode_t;
`else
    assign signed_sel   = 1'b0;
    assign signed_t_sel = 1'b0;
`endif

    // One radix step. Digits of A are treated as unsigned; for a negative signed A
    // its weight-2^WIDTH sign contribution is removed on the final step, so the
    // low PW bits of the accumulator equal the two's-complement product.
    logic                   last_step;
    logic [AW-1:0]          pp;
    logic [AW-1:0]          pp_shift;
    logic [AW-1:0]          corr;
    logic [AW-1:0]          acc_d;
    logic [AW-1:0]          md_d;

    assign last_step = (cnt_q == CW'(NCYC - 1));
    assign pp        = AW'(mr_q[RADIX_BITS-1:0]) * md_q;
    assign pp_shift  = pp << (cnt_q * RADIX_BITS);
    assign corr      = (a_neg_q && last_step) ? (md_q << WIDTH) : '0;
    assign acc_d     = acc_q + pp_shift - corr;

    assign md_d = signed_sel ? {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                             : {{(AW-WIDTH){1'b0}}, multiplicand};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mr_q        <= '0;
            md_q        <= '0;
            a_neg_q     <= 1'b0;
            acc_q       <= '0;
            data_t_q    <= 1'b0;
            ctrl_t_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q    <= ST_RUN;
                        mr_q       <= multiplier;
                        md_q       <= md_d;
                        a_neg_q    <= signed_sel & multiplier[WIDTH-1];
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        data_t_q   <= multiplier_t | multiplicand_t | signed_t_sel;
                        ctrl_t_q   <= ctrl_t_q | in_valid_t;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // No early exit: all NCYC steps run even on zero digits.
                    acc_q <= acc_d;
                    mr_q  <= mr_q >> RADIX_BITS;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A tainted consumer decision changes when we return to IDLE.
                    if (out_ready_t) begin
                        ctrl_t_q <= 1'b1;
                    end
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        acc_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The top RADIX_BITS of the accumulator only absorb carries of the last step.
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_q[AW-1:PW];

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign product     = out_valid_q ? acc_q[PW-1:0] : '0;
    assign in_ready_t  = ctrl_t_q;
    assign out_valid_t = ctrl_t_q;
    // Operand taint only reaches the product word, never the handshake timing.
    assign product_t   = out_valid_q ? (data_t_q | ctrl_t_q) : ctrl_t_q;

endmodule

// File: tb/tb_multiplier_radix_taint_track.sv
// Testbench for multiplier_radix_taint_track (WIDTH=8, RADIX_BITS=2, NCYC=4).
// Expected products come from plain integer multiplication, and the expected
// latency is the constant NCYC+1 counted from the accept cycle.
module tb_multiplier_radix_taint_track;

    localparam int W    = 8;
    localparam int R    = 2;
    localparam int NCYC = W / R;
    localparam int LAT  = NCYC + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_valid_t, in_ready, in_ready_t;
    logic [W-1:0]   a_in, b_in;
    logic           multiplier_t, multiplicand_t;
    logic           out_valid, out_valid_t, out_ready, out_ready_t;
    logic [2*W-1:0] product;
    logic           product_t;
`ifdef MULT_SIGNED_EN
    logic           signed_mode, signed_mode_t;
`endif

    int checks = 0;
    int errors = 0;

    multiplier_radix_taint_track #(.WIDTH(W), .RADIX_BITS(R)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_valid_t     (in_valid_t),
        .in_ready       (in_ready),
        .in_ready_t     (in_ready_t),
        .multiplier     (a_in),
        .multiplier_t   (multiplier_t),
        .multiplicand   (b_in),
        .multiplicand_t (multiplicand_t),
        .out_valid      (out_valid),
        .out_valid_t    (out_valid_t),
        .out_ready      (out_ready),
        .out_ready_t    (out_ready_t),
        .product        (product),
        .product_t      (product_t)
`ifdef MULT_SIGNED_EN
        ,
        .signed_mode    (signed_mode),
        .signed_mode_t  (signed_mode_t)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus: present one operation, then wait (bounded) for out_valid.
    // lat counts cycles from the accept cycle; out_ready is held low meanwhile.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic mt, input logic mdt, input logic ivt,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a_in = a; b_in = b;
        multiplier_t = mt; multiplicand_t = mdt; in_valid_t = ivt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Operands may change freely after accept.
        in_valid = 1'b0; in_valid_t = 1'b0;
        multiplier_t = 1'b0; multiplicand_t = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_valid_t = 0; a_in = 0; b_in = 0;
        multiplier_t = 0; multiplicand_t = 0; out_ready = 0; out_ready_t = 0;
`ifdef MULT_SIGNED_EN
        signed_mode = 0; signed_mode_t = 0;
`endif
        apply_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (product !== 16'd0) begin
            errors++;
            $display("FAIL reset_product: got %0d required 0", product);
        end
        checks++;
        if ({in_ready_t, out_valid_t, product_t} !== 3'b000) begin
            errors++;
            $display("FAIL reset_taints: got %b required 000", {in_ready_t, out_valid_t, product_t});
        end
    endtask

    task automatic test_directed();
        int lat;
        do_op(8'd13, 8'd11, 0, 0, 0, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL directed_latency: got %0d required %0d", lat, LAT);
        end
        checks++;
        if (product !== 16'd143 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL directed_product: product=%0d in_ready=%b required 143 0", product, in_ready);
        end
        checks++;
        if ({in_ready_t, out_valid_t, product_t} !== 3'b000) begin
            errors++;
            $display("FAIL directed_taints: got %b required 000", {in_ready_t, out_valid_t, product_t});
        end
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || product !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL directed_release: out_valid=%b product=%0d in_ready=%b required 0 0 1",
                     out_valid, product, in_ready);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] ca [5];
        logic [W-1:0] cb [5];
        int lat;
        int exp_p;
        ca = '{8'd255, 8'd0, 8'd255, 8'd1,   8'd128};
        cb = '{8'd255, 8'd0, 8'd1,   8'd255, 8'd2};
        for (int i = 0; i < 5; i++) begin
            exp_p = int'(ca[i]) * int'(cb[i]);
            do_op(ca[i], cb[i], 0, 0, 0, lat);
            checks++;
            if (lat !== LAT || product !== 16'(exp_p)) begin
                errors++;
                $display("FAIL corner_%0d: %0d*%0d product=%0d lat=%0d required %0d lat %0d",
                         i, ca[i], cb[i], product, lat, exp_p, LAT);
            end
            finish_op();
        end
    endtask

    task automatic test_data_taint();
        int lat;
        do_op(8'd7, 8'd9, 1, 0, 0, lat);
        checks++;
        if (product !== 16'd63 || product_t !== 1'b1) begin
            errors++;
            $display("FAIL data_taint_product: product=%0d product_t=%b required 63 1", product, product_t);
        end
        checks++;
        if (out_valid_t !== 1'b0 || in_ready_t !== 1'b0) begin
            errors++;
            $display("FAIL data_taint_ctrl: out_valid_t=%b in_ready_t=%b required 0 0", out_valid_t, in_ready_t);
        end
        finish_op();
        checks++;
        if (product_t !== 1'b0) begin
            errors++;
            $display("FAIL data_taint_idle: product_t=%b required 0", product_t);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic mt, mdt;
        int lat, hold, exp_p;
        for (int n = 0; n < 24; n++) begin
            a = W'($urandom); b = W'($urandom);
            mt = 1'($urandom); mdt = 1'($urandom);
            exp_p = int'(a) * int'(b);
            do_op(a, b, mt, mdt, 0, lat);
            checks++;
            if (lat !== LAT || product !== 16'(exp_p) || product_t !== (mt | mdt) || out_valid_t !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: %0d*%0d product=%0d lat=%0d product_t=%b ov_t=%b required %0d %0d %b 0",
                         n, a, b, product, lat, product_t, out_valid_t, exp_p, LAT, mt | mdt);
            end
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || product !== 16'(exp_p)) begin
                    errors++;
                    $display("FAIL random_hold_%0d: out_valid=%b product=%0d required 1 %0d",
                             n, out_valid, product, exp_p);
                end
            end
            finish_op();
            checks++;
            if (out_valid !== 1'b0 || product !== 16'd0) begin
                errors++;
                $display("FAIL random_release_%0d: out_valid=%b product=%0d required 0 0", n, out_valid, product);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(8'd21, 8'd3, 0, 0, 0, lat);
        // Same cycle: consumer takes the product while a new op is offered.
        out_ready = 1'b1; in_valid = 1'b1; a_in = 8'd5; b_in = 8'd6;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bypass: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== LAT || product !== 16'd30) begin
            errors++;
            $display("FAIL b2b_second: product=%0d lat=%0d required 30 %0d", product, lat, LAT);
        end
        finish_op();
    endtask

    task automatic test_midrun_reset();
        int seen;
        a_in = 8'd200; b_in = 8'd100; multiplicand_t = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; multiplicand_t = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || product !== 16'd0 || in_ready !== 1'b1 ||
            {in_ready_t, out_valid_t, product_t} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_reset: out_valid=%b product=%0d in_ready=%b taints=%b required 0 0 1 000",
                     out_valid, product, in_ready, {in_ready_t, out_valid_t, product_t});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_abort: out_valid cycles=%0d in_ready=%b required 0 1", seen, in_ready);
        end
    endtask

    task automatic test_ctrl_taint();
        int lat;
        do_op(8'd3, 8'd4, 0, 0, 1, lat);
        checks++;
        if (product !== 16'd12 || {in_ready_t, out_valid_t, product_t} !== 3'b111) begin
            errors++;
            $display("FAIL ctrl_taint_done: product=%0d taints=%b required 12 111",
                     product, {in_ready_t, out_valid_t, product_t});
        end
        finish_op();
        do_op(8'd2, 8'd5, 0, 0, 0, lat);
        checks++;
        if ({in_ready_t, out_valid_t, product_t} !== 3'b111 || product !== 16'd10) begin
            errors++;
            $display("FAIL ctrl_taint_sticky: product=%0d taints=%b required 10 111",
                     product, {in_ready_t, out_valid_t, product_t});
        end
        finish_op();
        apply_reset();
        checks++;
        if ({in_ready_t, out_valid_t, product_t} !== 3'b000) begin
            errors++;
            $display("FAIL ctrl_taint_cleared: taints=%b required 000", {in_ready_t, out_valid_t, product_t});
        end
        // Tainted out_ready observed while out_valid taints control.
        do_op(8'd2, 8'd2, 0, 0, 0, lat);
        out_ready_t = 1'b1;
        @(posedge clk); #1;
        out_ready_t = 1'b0;
        checks++;
        if (out_valid_t !== 1'b1 || out_valid !== 1'b1 || product !== 16'd4) begin
            errors++;
            $display("FAIL out_ready_taint: out_valid_t=%b out_valid=%b product=%0d required 1 1 4",
                     out_valid_t, out_valid, product);
        end
        finish_op();
        apply_reset();
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] a, b;
        int lat, exp_p;
        signed_mode = 1'b1;
        do_op(8'hFD, 8'd5, 0, 0, 0, lat);
        checks++;
        if (product !== 16'hFFF1 || lat !== LAT) begin
            errors++;
            $display("FAIL signed_directed: product=%h lat=%0d required fff1 %0d", product, lat, LAT);
        end
        finish_op();
        for (int n = 0; n < 8; n++) begin
            a = W'($urandom); b = W'($urandom);
            exp_p = int'($signed(a)) * int'($signed(b));
            signed_mode = 1'b1;
            do_op(a, b, 0, 0, 0, lat);
            checks++;
            if (product !== 16'(exp_p) || lat !== LAT) begin
                errors++;
                $display("FAIL signed_random_%0d: %h*%h product=%h required %h",
                         n, a, b, product, 16'(exp_p));
            end
            finish_op();
        end
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        test_reset();
        test_directed();
        test_corners();
        test_data_taint();
        test_random();
        test_back_to_back();
        test_midrun_reset();
        test_ctrl_taint();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
